// File: rtl/fadd_ctrl_pkg.sv
// Shared constants and tag type for the shared-fadd arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FWIDTH operand width, FADD_NSTAGE default fadd latency,
//           fadd_tag_t {valid, id} carried alongside each issued op.
package fadd_ctrl_pkg;

  localparam int FWIDTH      = 32;
  localparam int FADD_NSTAGE = 7;

  typedef struct packed {
    logic       valid;
    logic [2:0] id;
  } fadd_tag_t;

endpackage

// File: rtl/fadd_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick of one requester.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller masks req to suppress grants.
// Ports: req (request vector), ptr (last granted index, searched from
//        ptr+1 upward with wrap), gnt (one-hot or zero grant).
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt
);

  logic [PW:0] idx;
  logic        found;

  // One extra bit on idx lets ptr+i exceed NREQ-1 before the wrap, which
  // keeps the modulo to a single compare-and-subtract for any NREQ.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = {1'b0, ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
      if (!found && req[idx[PW-1:0]]) begin
        gnt[idx[PW-1:0]] = 1'b1;
        found            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fadd_arbiter.sv
// fadd_arbiter: round-robin sharing of one pipelined fadd among NREQ requesters.
// Latency: accept edge E0 -> resp_valid pulse in the cycle after E0+NSTAGE+1.
// Backpressure: req_ready is a combinational grant (zero while drain or reset);
//               responses are one-cycle pulses with no backpressure.
// Ports: clk/rstn; req_valid/req_ready/req_x1/req_x2 per requester (32-bit
//        lanes packed by index); resp_valid (one-hot) / resp_y; drain blocks
//        new grants; busy / inflight status; fa_x1/fa_x2 registered operands
//        to the external fadd, fa_y its result.
module fadd_arbiter
  import fadd_ctrl_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int NSTAGE = FADD_NSTAGE
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NREQ-1:0]               req_valid,
  output logic [NREQ-1:0]               req_ready,
  input  logic [FWIDTH*NREQ-1:0]        req_x1,
  input  logic [FWIDTH*NREQ-1:0]        req_x2,
  output logic [NREQ-1:0]               resp_valid,
  output logic [FWIDTH-1:0]             resp_y,
  input  logic                          drain,
  output logic                          busy,
  output logic [$clog2(NSTAGE+2)-1:0]   inflight,
  output logic [FWIDTH-1:0]             fa_x1,
  output logic [FWIDTH-1:0]             fa_x2,
  input  logic [FWIDTH-1:0]             fa_y
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(NSTAGE+2);

  logic [IW-1:0]           ptr;
  logic [NREQ-1:0]         req_elig;
  logic [NREQ-1:0]         gnt;
  logic                    accept;
  logic [2:0]              gnt_id;
  logic [FWIDTH-1:0]       sel_x1;
  logic [FWIDTH-1:0]       sel_x2;
  fadd_tag_t [NSTAGE:0]    tag_pipe;
  fadd_tag_t               tail;

  // Gating with rstn keeps req_ready low while reset is asserted.
  assign req_elig  = req_valid & {NREQ{rstn & ~drain}};
  assign req_ready = gnt;
  assign accept    = |gnt;
  assign tail      = tag_pipe[NSTAGE];

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (IW)
  ) u_rr (
    .req (req_elig),
    .ptr (ptr),
    .gnt (gnt)
  );

  // One-hot grant to index plus operand select.
  always_comb begin
    gnt_id = '0;
    sel_x1 = '0;
    sel_x2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gnt_id = 3'(i);
        sel_x1 = req_x1[i*FWIDTH +: FWIDTH];
        sel_x2 = req_x2[i*FWIDTH +: FWIDTH];
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int s = 0; s <= NSTAGE; s++) busy = busy | tag_pipe[s].valid;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr        <= IW'(NREQ-1);   // requester 0 searched first
      fa_x1      <= '0;
      fa_x2      <= '0;
      tag_pipe   <= '0;
      resp_valid <= '0;
      resp_y     <= '0;
      inflight   <= '0;
    end else begin
      if (accept) begin
        fa_x1 <= sel_x1;
        fa_x2 <= sel_x2;
        ptr   <= gnt_id[IW-1:0];
      end
      // Tag pipe is one stage deeper than fadd so the tail lines up with
      // fa_y on the edge that loads the response register.
      tag_pipe[0] <= fadd_tag_t'{valid: accept, id: gnt_id};
      for (int s = 1; s <= NSTAGE; s++) tag_pipe[s] <= tag_pipe[s-1];
      resp_valid <= tail.valid ? (NREQ'(1) << tail.id) : '0;
      resp_y     <= fa_y;
      case ({accept, tail.valid})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

endmodule
